seq_subtractor: RTL and testbench



---
 rtl/seq_subtractor_pkg.sv | 18 +
 rtl/seq_subtractor_slice.sv | 23 ++
 rtl/seq_subtractor.sv | 136 +++++++++++++
 tb/tb_seq_subtractor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_subtractor_pkg.sv
// Shared types and elaboration helpers for the slice-serial subtractor.
package seq_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   function automatic int unsigned num_slices(input int unsigned width, input int unsigned slice);
      return (slice == 0) ? 1 : width / slice;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_subtractor_slice.sv
// Combinational SLICE-bit ripple of full-subtractor cells: d = x - y - bin.
module subtractor_slice #(
   parameter int unsigned SLICE = 4
) (
   input  logic [SLICE-1:0] x,
   input  logic [SLICE-1:0] y,
   input  logic             bin,
   output logic [SLICE-1:0] d,
   output logic             bout
);

   logic [SLICE:0] bw;

   assign bw[0] = bin;

   for (genvar i = 0; i < SLICE; i++) begin : g_cell
      assign d[i]    = x[i] ^ y[i] ^ bw[i];
      assign bw[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bw[i]);
   end

   assign bout = bw[SLICE];

endmodule

// File: rtl/seq_subtractor.sv
// Multi-cycle a - b - borrow_in, SLICE bits per clock LSB first, with
// optional saturate-at-zero and a registered zero flag.
module seq_subtractor
   import seq_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   input  logic             saturate,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             zero
);

   localparam int unsigned N  = num_slices(WIDTH, SLICE);
   localparam int unsigned CW = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("seq_subtractor: WIDTH must be a non-zero multiple of SLICE");
   end

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bor_q, bor_d, sat_q, sat_d;
   logic             bout_q, bout_d, zero_q, zero_d;

   logic [SLICE-1:0] sl_d;
   logic             sl_bout;
   logic [WIDTH-1:0] shifted;

   subtractor_slice #(.SLICE(SLICE)) u_slice (
      .x    (a_q[SLICE-1:0]),
      .y    (b_q[SLICE-1:0]),
      .bin  (bor_q),
      .d    (sl_d),
      .bout (sl_bout)
   );

   // Operands shift right each RUN cycle; result slices enter from the top so
   // slice 0 ends up in the low bits after N cycles.
   assign shifted = (diff_q >> SLICE) | (WIDTH'(sl_d) << (WIDTH - SLICE));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      bor_d     = bor_q;
      sat_d     = sat_q;
      diff_d    = diff_q;
      bout_d    = bout_q;
      zero_d    = zero_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               bor_d   = borrow_in;
               sat_d   = saturate;
               diff_d  = '0;
               bout_d  = 1'b0;
               zero_d  = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d    = a_q >> SLICE;
            b_d    = b_q >> SLICE;
            bor_d  = sl_bout;
            diff_d = shifted;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               bout_d = sl_bout;
               if (sat_q && sl_bout) begin
                  diff_d = '0;
               end
               zero_d  = (diff_d == '0);
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         bor_q   <= 1'b0;
         sat_q   <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         bor_q   <= bor_d;
         sat_q   <= sat_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         zero_q  <= zero_d;
      end
   end

   assign diff       = diff_q;
   assign borrow_out = bout_q;
   assign zero       = zero_q;

endmodule

// File: tb/tb_seq_subtractor.sv
// Scoreboard bench: WIDTH=8/SLICE=2 and WIDTH=8/SLICE=8 instances.
module tb_seq_subtractor;

   typedef struct packed {
      logic [7:0] diff;
      logic       bout;
      logic       zero;
   } exp_t;

   logic       clk;
   logic       rst_n;

   logic       u1_iv, u1_ir, u1_bin, u1_sat, u1_ov, u1_or, u1_bout, u1_zero;
   logic [7:0] u1_a, u1_b, u1_diff;
   logic       u2_iv, u2_ir, u2_bin, u2_sat, u2_ov, u2_or, u2_bout, u2_zero;
   logic [7:0] u2_a, u2_b, u2_diff;

   exp_t q1[$];
   exp_t q2[$];

   int unsigned n_chk = 0;
   int unsigned n_bad = 0;

   seq_subtractor #(.WIDTH(8), .SLICE(2)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (u1_iv),
      .in_ready   (u1_ir),
      .a          (u1_a),
      .b          (u1_b),
      .borrow_in  (u1_bin),
      .saturate   (u1_sat),
      .out_valid  (u1_ov),
      .out_ready  (u1_or),
      .diff       (u1_diff),
      .borrow_out (u1_bout),
      .zero       (u1_zero)
   );

   seq_subtractor #(.WIDTH(8), .SLICE(8)) u_dut_w (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (u2_iv),
      .in_ready   (u2_ir),
      .a          (u2_a),
      .b          (u2_b),
      .borrow_in  (u2_bin),
      .saturate   (u2_sat),
      .out_valid  (u2_ov),
      .out_ready  (u2_or),
      .diff       (u2_diff),
      .borrow_out (u2_bout),
      .zero       (u2_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                  input logic bin, input logic sat);
      logic [8:0] full;
      exp_t       e;
      full   = {1'b0, a} - {1'b0, b} - {8'd0, bin};
      e.bout = full[8];
      e.diff = (sat && full[8]) ? 8'h00 : full[7:0];
      e.zero = (e.diff == 8'h00);
      return e;
   endfunction

   // Output monitor: a result is consumed on the edge following a sample
   // with out_valid && out_ready.
   always begin : mon
      exp_t e;
      @(negedge clk);
      #1;
      if (rst_n && u1_ov && u1_or) begin
         if (q1.size() == 0) chk("sb1_empty", 32'd1, 32'd0);
         else begin
            e = q1.pop_front();
            chk("u1_diff", 32'(u1_diff), 32'(e.diff));
            chk("u1_bout", 32'(u1_bout), 32'(e.bout));
            chk("u1_zero", 32'(u1_zero), 32'(e.zero));
         end
      end
      if (rst_n && u2_ov && u2_or) begin
         if (q2.size() == 0) chk("sb2_empty", 32'd1, 32'd0);
         else begin
            e = q2.pop_front();
            chk("u2_diff", 32'(u2_diff), 32'(e.diff));
            chk("u2_bout", 32'(u2_bout), 32'(e.bout));
            chk("u2_zero", 32'(u2_zero), 32'(e.zero));
         end
      end
   end

   task automatic wait_ov(input bit sel, input logic want, output int unsigned cyc);
      cyc = 0;
      while (((sel ? u2_ov : u1_ov) !== want) && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                     input logic bin, input logic sat, input int unsigned n);
      int unsigned cyc;
      @(negedge clk);
      if (!sel) begin
         u1_a = a; u1_b = b; u1_bin = bin; u1_sat = sat; u1_iv = 1'b1;
         chk("u1_in_ready", 32'(u1_ir), 32'd1);
         q1.push_back(model(a, b, bin, sat));
      end else begin
         u2_a = a; u2_b = b; u2_bin = bin; u2_sat = sat; u2_iv = 1'b1;
         chk("u2_in_ready", 32'(u2_ir), 32'd1);
         q2.push_back(model(a, b, bin, sat));
      end
      @(posedge clk);
      #1;
      u1_iv = 1'b0;
      u2_iv = 1'b0;
      wait_ov(sel, 1'b1, cyc);
      chk("latency", 32'(cyc + 1), 32'(n + 1));
      wait_ov(sel, 1'b0, cyc);
      chk("ov_drop", 32'(cyc < 40), 32'd1);
   endtask

   initial begin : main
      int unsigned cyc;
      rst_n = 1'b0;
      u1_iv = 1'b0; u1_a = '0; u1_b = '0; u1_bin = 1'b0; u1_sat = 1'b0; u1_or = 1'b1;
      u2_iv = 1'b0; u2_a = '0; u2_b = '0; u2_bin = 1'b0; u2_sat = 1'b0; u2_or = 1'b1;
      #1;
      chk("rst_in_ready", 32'(u1_ir), 32'd1);
      chk("rst_out_valid", 32'(u1_ov), 32'd0);
      chk("rst_diff", 32'(u1_diff), 32'd0);
      chk("rst_bout", 32'(u1_bout), 32'd0);
      chk("rst_zero", 32'(u1_zero), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      op(1'b0, 8'h5A, 8'h23, 1'b0, 1'b0, 4);
      op(1'b0, 8'h10, 8'h20, 1'b0, 1'b0, 4);
      op(1'b0, 8'h10, 8'h20, 1'b0, 1'b1, 4);
      op(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 4);
      op(1'b0, 8'hFF, 8'h00, 1'b1, 1'b1, 4);
      op(1'b0, 8'h37, 8'h37, 1'b0, 1'b0, 4);
      op(1'b0, 8'h80, 8'h7F, 1'b1, 1'b0, 4);
      for (int i = 0; i < 6; i++) begin
         op(1'b0, 8'($urandom_range(255)), 8'($urandom_range(255)),
            1'($urandom_range(1)), 1'($urandom_range(1)), 4);
      end

      // Hold in DONE while a second request is pending.
      @(negedge clk);
      u1_or = 1'b0;
      u1_a = 8'h10; u1_b = 8'h20; u1_bin = 1'b0; u1_sat = 1'b0; u1_iv = 1'b1;
      q1.push_back(model(8'h10, 8'h20, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      u1_iv = 1'b0;
      wait_ov(1'b0, 1'b1, cyc);
      chk("hold_reach_done", 32'(cyc), 32'd4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         u1_a = 8'hC3; u1_b = 8'h42; u1_bin = 1'b0; u1_sat = 1'b1; u1_iv = 1'b1;
         #1;
         chk("hold_ov", 32'(u1_ov), 32'd1);
         chk("hold_in_ready", 32'(u1_ir), 32'd0);
         chk("hold_diff", 32'(u1_diff), 32'h F0);
         chk("hold_bout", 32'(u1_bout), 32'd1);
         chk("hold_zero", 32'(u1_zero), 32'd0);
      end
      @(negedge clk);
      u1_or = 1'b1;
      q1.push_back(model(8'hC3, 8'h42, 1'b0, 1'b1));
      @(posedge clk);
      #1;
      chk("release_idle_rdy", 32'(u1_ir), 32'd1);
      chk("release_ov", 32'(u1_ov), 32'd0);
      @(posedge clk);
      #1;
      chk("second_accepted", 32'(u1_ir), 32'd0);
      u1_iv = 1'b0;
      wait_ov(1'b0, 1'b1, cyc);
      chk("second_latency", 32'(cyc), 32'd4);
      wait_ov(1'b0, 1'b0, cyc);

      // Asynchronous reset during slice 2.
      @(negedge clk);
      u1_a = 8'h5A; u1_b = 8'h11; u1_bin = 1'b0; u1_sat = 1'b0; u1_iv = 1'b1;
      @(posedge clk);
      #1;
      u1_iv = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 32'(u1_ir), 32'd1);
      chk("abort_ov", 32'(u1_ov), 32'd0);
      chk("abort_diff", 32'(u1_diff), 32'd0);
      chk("abort_bout", 32'(u1_bout), 32'd0);
      chk("abort_zero", 32'(u1_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      op(1'b0, 8'h37, 8'h01, 1'b0, 1'b0, 4);

      // Single-slice instance.
      op(1'b1, 8'h37, 8'h37, 1'b0, 1'b0, 1);
      op(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1);
      op(1'b1, 8'h10, 8'h20, 1'b0, 1'b1, 1);
      op(1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0, 1);

      repeat (3) @(negedge clk);
      chk("sb1_drained", 32'(q1.size()), 32'd0);
      chk("sb2_drained", 32'(q2.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
